// File: rtl/bcd_updown_counter.sv
// Single-digit synchronous up/down BCD counter; Q = {A,B,C,D} straight from the flops.
// Define BCD_TC_EN to add the TC (terminal count / cascade enable) output.
module bcd_updown_counter #(
   parameter logic [3:0] RESET_VALUE = 4'd0
) (
   input  logic clk,
   input  logic reset,
   input  logic X,
   output logic A,
   output logic B,
   output logic C,
`ifdef BCD_TC_EN
   output logic D,
   output logic TC
`else
   output logic D
`endif
);

   logic [3:0] r_q;
   logic [3:0] w_next;

   if (RESET_VALUE > 4'd9) begin : g_bad_reset_value
      $error("bcd_updown_counter: RESET_VALUE must be a BCD digit (0-9)");
   end

   // Codes 10-15 fall to the default and recover to zero in one edge.
   always_comb begin
      w_next = 4'd0;
      case (r_q)
         4'd0:    w_next = X ? 4'd9 : 4'd1;
         4'd1:    w_next = X ? 4'd0 : 4'd2;
         4'd2:    w_next = X ? 4'd1 : 4'd3;
         4'd3:    w_next = X ? 4'd2 : 4'd4;
         4'd4:    w_next = X ? 4'd3 : 4'd5;
         4'd5:    w_next = X ? 4'd4 : 4'd6;
         4'd6:    w_next = X ? 4'd5 : 4'd7;
         4'd7:    w_next = X ? 4'd6 : 4'd8;
         4'd8:    w_next = X ? 4'd7 : 4'd9;
         4'd9:    w_next = X ? 4'd8 : 4'd0;
         default: w_next = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= w_next;
      end
   end

   assign {A, B, C, D} = r_q;

`ifdef BCD_TC_EN
   // High when the coming edge wraps the digit; held low during reset.
   assign TC = reset & ((~X & (r_q == 4'd9)) | (X & (r_q == 4'd0)));
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised self-checking bench for bcd_updown_counter against a modulo-10 digit model.
// TC checks are included when BCD_TC_EN is defined.
module tb_bcd_updown_counter;

   logic clk;
   logic reset;
   logic X;
   logic A, B, C, D;
`ifdef BCD_TC_EN
   logic TC;
`endif

   int vectors;
   int miscompares;
   int m_q;

   bcd_updown_counter #(.RESET_VALUE(4'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .X     (X),
      .A     (A),
      .B     (B),
      .C     (C),
`ifdef BCD_TC_EN
      .D     (D),
      .TC    (TC)
`else
      .D     (D)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge; the model advances by the digit rules, then outputs settle for sampling.
   task automatic tick();
      @(posedge clk);
      if (!reset)
         m_q = 0;
      else if (m_q > 9)
         m_q = 0;
      else if (X == 1'b0)
         m_q = (m_q + 1) % 10;
      else
         m_q = (m_q + 9) % 10;
      #1;
   endtask

   function automatic logic tc_model();
      return reset && ((X == 1'b0 && m_q == 9) || (X == 1'b1 && m_q == 0));
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      X = 1'b0;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected 0000", {A, B, C, D});
      end
`ifdef BCD_TC_EN
      X = 1'b1;
      #1;
      vectors++;
      if (TC !== 1'b0) begin
         miscompares++;
         $display("FAIL tc_in_reset: got %b expected 0", TC);
      end
      X = 1'b0;
`endif
      reset = 1'b1;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'(m_q)) begin
         miscompares++;
         $display("FAIL reset_release: got %b expected %b", {A, B, C, D}, 4'(m_q));
      end
   endtask

   task automatic test_up_wrap();
      reset = 1'b0;
      X = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++;
         if ({A, B, C, D} !== 4'(i % 10) || m_q != i % 10) begin
            miscompares++;
            $display("FAIL up_wrap step %0d: got %b expected %b", i, {A, B, C, D}, 4'(i % 10));
         end
`ifdef BCD_TC_EN
         vectors++;
         if (TC !== ((i % 10) == 9)) begin
            miscompares++;
            $display("FAIL up_tc step %0d: got %b expected %b", i, TC, (i % 10) == 9);
         end
`endif
      end
   endtask

   task automatic test_down_wrap();
      int exp_q;
      reset = 1'b0;
      X = 1'b1;
      tick();
      reset = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         exp_q = (10 - (i % 10)) % 10;
         vectors++;
         if ({A, B, C, D} !== 4'(exp_q)) begin
            miscompares++;
            $display("FAIL down_wrap step %0d: got %b expected %b", i, {A, B, C, D}, 4'(exp_q));
         end
`ifdef BCD_TC_EN
         vectors++;
         if (TC !== (exp_q == 0)) begin
            miscompares++;
            $display("FAIL down_tc step %0d: got %b expected %b", i, TC, exp_q == 0);
         end
`endif
      end
   endtask

   task automatic test_dir_change();
      reset = 1'b0;
      X = 1'b0;
      tick();
      reset = 1'b1;
      repeat (5) tick();
      X = 1'b1;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'b0100) begin
         miscompares++;
         $display("FAIL dir_change_down: got %b expected 0100", {A, B, C, D});
      end
      X = 1'b0;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'b0101) begin
         miscompares++;
         $display("FAIL dir_change_up: got %b expected 0101", {A, B, C, D});
      end
   endtask

   task automatic test_reset_mid();
      X = 1'b0;
      while (m_q != 7) tick();
      reset = 1'b0;
      X = 1'b1;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_mid: got %b expected 0000", {A, B, C, D});
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({A, B, C, D} !== 4'b1001) begin
         miscompares++;
         $display("FAIL reset_resume: got %b expected 1001", {A, B, C, D});
      end
   endtask

   task automatic test_illegal();
      for (int code = 10; code <= 15; code++) begin
         @(negedge clk);
         force dut.r_q = 4'(code);
         #1;
         release dut.r_q;
         m_q = code;
         vectors++;
         if ({A, B, C, D} !== 4'(code)) begin
            miscompares++;
            $display("FAIL illegal_load %0d: got %b expected %b", code, {A, B, C, D}, 4'(code));
         end
         X = (code == 12) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         vectors++;
         if ({A, B, C, D} !== 4'b0000) begin
            miscompares++;
            $display("FAIL illegal_recover %0d: got %b expected 0000", code, {A, B, C, D});
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         X = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 7) != 0);
`ifdef BCD_TC_EN
         #1;
         vectors++;
         if (TC !== tc_model()) begin
            miscompares++;
            $display("FAIL random_tc %0d: got %b expected %b", i, TC, tc_model());
         end
`endif
         tick();
         vectors++;
         if ({A, B, C, D} !== 4'(m_q)) begin
            miscompares++;
            $display("FAIL random_q %0d: got %b expected %b", i, {A, B, C, D}, 4'(m_q));
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      m_q = 0;
      reset = 1'b0;
      X = 1'b0;
      #2;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_dir_change();
      test_reset_mid();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Single-digit synchronous up/down BCD counter built from four D flip-flops; state bits A (MSB), B, C, D (LSB) drive the outputs directly.
- X selects direction: 0 = count up, 1 = count down. Wraps within the range 0-9.
- Leaf block used as a counter stage or teaching-level sequential element; no handshake.

Parameters:
- RESET_VALUE, 4'd0, BCD code loaded on reset. Legal values are 0-9 only; any value above 9 is a configuration error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset; sampled on the rising edge of clk
- X  input  1  direction; 0 = up, 1 = down
- A  output  1  count bit 3 (MSB)
- B  output  1  count bit 2
- C  output  1  count bit 1
- D  output  1  count bit 0 (LSB)

Behaviour:
- State: 4-bit register Q = {A,B,C,D}. Outputs come directly from the flip-flops with no combinational path from X to A-D.
- Next-state logic is explicit D-input equations (or an equivalent case table) feeding four D flip-flops, all clocked by clk.
- Reset: if reset==0 at a rising clk edge, Q <= RESET_VALUE (default 0000). Reset takes priority over X. Asserting reset mid-count clears Q on the next edge.
- Before the first reset edge, Q is undefined; no power-on value is guaranteed.
- Up (X=0, reset=1): Q <= Q+1 for Q in 0-8; 9 -> 0.
- Down (X=1, reset=1): Q <= Q-1 for Q in 1-9; 0 -> 9.
- Illegal codes 10-15 (reachable only via X-propagation or fault): next edge forces Q <= 0000 regardless of X. The counter recovers in one cycle.
- Latency: one clock. A change on X affects the very next edge. X toggling every cycle alternates direction edge by edge.
- X is sampled only at the rising edge; glitches between edges have no effect.

Optional Feature:
- Macro BCD_TC_EN adds output port TC (1 bit, combinational from Q and X).
- TC = 1 when (X==0 and Q==9) or (X==1 and Q==0), i.e. the next edge wraps. TC = 0 while reset==0.
- TC serves as the cascade enable for the next BCD digit.
- Without the macro, the TC port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: clk period 10, reset=0 over the first edge -> ABCD=0000. Release reset with X=0 -> ABCD = 0001 on the next edge.
- Up count and wrap: X=0 for 10 edges from 0000 -> 1,2,...,9 then 0000 on the 10th edge. With BCD_TC_EN, TC=1 only while Q=9.
- Down count and wrap: from 0000, set X=1 -> 1001, 1000, 0111 ... 0000, then 1001 again. With BCD_TC_EN, TC=1 only while Q=0.
- Direction change mid-count: count up to 0101, set X=1 -> 0100 on the next edge. Set X back to 0 -> 0101.
- Reset mid-operation: at Q=0111, drive reset=0 for one edge with X=1 -> 0000, not 0110. Reset high again -> counting resumes from 0000 in the X direction.
- Illegal-state recovery: force Q=1100 (force/deposit), release, X=1 -> next edge 0000.
